cu_mod1_1: RTL
==============

Name: cu_mod1_1

Overview:
- Control unit for module-1 stage 1: the consumer of the stage-0 control handshake, taking its `valid_fac8_0` beats and `alert_mod10` frame marker.
- Tracks frame position and delay-line occupancy of the stage-1 single-delay-feedback butterfly.
- Drives the butterfly enable, the trivial −j rotation enable, the twiddle index, and a re-timed valid/alert pair to the next module.
- Handles gapped input, back-to-back frames and end-of-frame flush.

Parameters:
- HALF_DEPTH, 4, stage-1 delay-line depth in beats; power of two, ≥2.
- FRAME_BEATS, 32, beats per frame; power of two, ≥ 4*HALF_DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- valid_in  in  1  beat valid from stage 0 (`valid_fac8_0`).
- alert_in  in  1  frame-start marker from stage 0 (`alert_mod10`); qualified only with valid_in.
- bf_en  out  1  butterfly add/sub enable for the beat accepted on the previous cycle.
- negj_en  out  1  apply −j rotation to the butterfly output.
- tw_idx  out  $clog2(FRAME_BEATS)  output-frame beat index, valid with valid_out.
- valid_out  out  1  beat valid to the next module.
- alert_out  out  1  one-cycle pulse on the first output beat of each frame.
- sync_err  out  1  sticky frame-misalignment flag.

Behaviour:
- Reset (async, any time, including mid-frame): all outputs 0; state=IDLE; frm_cnt=0, occ=0, out_cnt=0.
- All outputs are registered, one cycle after the qualifying edge.
- Accepted beat (acc):
  - IDLE, or FLUSH with occ>0: valid_in & alert_in.
  - ACTIVE: valid_in.
- Ignored input:
  - valid_in without alert_in in IDLE or FLUSH is ignored.
  - alert_in without valid_in is always ignored.
- Frame counter k=frm_cnt (index of the accepted beat):
  - alert_in on acc forces k=0.
  - Otherwise k is the previous count + 1, modulo FRAME_BEATS.
- Mid-frame alert: alert_in on acc in ACTIVE with expected k≠0 sets sync_err=1 and restarts at k=0; occ is untouched.
- Butterfly controls (registered on acc, else 0):
  - bf_en = bit log2(HALF_DEPTH) of k.
  - negj_en = bf_en & bit log2(2*HALF_DEPTH) of k.
- Occupancy, occ in 0..HALF_DEPTH:
  - acc with occ<HALF_DEPTH: occ+1, no output.
  - acc with occ==HALF_DEPTH: push one/pop one, valid_out=1.
- FSM:
  - IDLE -> ACTIVE on acc.
  - ACTIVE -> FLUSH on acc with k==FRAME_BEATS-1.
  - FLUSH:
    - Every cycle with occ>0: valid_out=1.
    - If no acc that cycle, occ−1.
    - If acc (new frame) that cycle, occ unchanged, next state ACTIVE with k=0.
    - occ reaching 0 with no acc -> IDLE.
  - A new-frame acc in FLUSH therefore yields gapless output for continuous frames.
- Output index: out_cnt increments modulo FRAME_BEATS on each valid_out.
  - tw_idx = out_cnt of that beat.
  - alert_out = valid_out & (out_cnt==0).
- Gaps in valid_in during ACTIVE stall all counters; outputs are 0 in stalled cycles.
- sync_err clears only on rst.
- Latency: first valid_out is 1 cycle after the (HALF_DEPTH+1)-th accepted beat of a frame. The final HALF_DEPTH outputs of a frame appear on consecutive cycles after the last input beat.

Decomposition:
- Package `fft_ctrl_pkg`:
  - state enum (IDLE, ACTIVE, FLUSH).
  - HALF_DEPTH / FRAME_BEATS defaults.
  - derived widths: FRM_W=$clog2(FRAME_BEATS), OCC_W=$clog2(HALF_DEPTH+1).
- One sub-module is natural: `frame_beat_cnt`, a modulo-FRAME_BEATS counter with enable and sync-load-to-zero. It is used for both frm_cnt and out_cnt.

Test Plan:
- Single frame, continuous valid with alert on beat 0:
  - valid_out high for 32 cycles, starting 1 cycle after beat 4.
  - alert_out coincides with the first of those cycles (tw_idx=0).
  - Last 4 outputs are in FLUSH.
  - Back to IDLE after them.
- bf_en / negj_en pattern over beats 0..15:
  - bf_en = 0000 1111 0000 1111.
  - negj_en = 0000 0000 0000 1111.
- Back-to-back frames (new alert on the cycle after beat 31):
  - valid_out gapless for 64 beats.
  - alert_out pulses at tw_idx=0 twice, 32 cycles apart.
  - occ never drops below 3.
- valid_in toggling 1010…:
  - counters stall on idle cycles.
  - bf_en/valid_out only on cycles after accepted beats.
  - 32 total outputs.
- alert_in at beat 10 mid-frame:
  - sync_err=1 and stays high.
  - frm_cnt restarts at 0.
  - Output stream continues without losing occ.
- rst asserted mid-frame at beat 17:
  - all outputs 0 immediately (asynchronous).
  - valid_in without alert afterwards is ignored until the next alert.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fft_ctrl_pkg
// Shared definitions for the module-1 stage-1 control unit:
//   - state_t     : control FSM states (IDLE, ACTIVE, FLUSH)
//   - DEF_*       : default delay-line depth and frame length
//   - FRM_W/OCC_W : frame-index and occupancy widths for the defaults
// ---------------------------------------------------------------------------
package fft_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam int DEF_HALF_DEPTH  = 4;
  localparam int DEF_FRAME_BEATS = 32;

  localparam int FRM_W = $clog2(DEF_FRAME_BEATS);
  localparam int OCC_W = $clog2(DEF_HALF_DEPTH + 1);

endpackage

// File: rtl/frame_beat_cnt.sv
// ---------------------------------------------------------------------------
// frame_beat_cnt
// Modulo-FRAME_BEATS beat counter with enable and synchronous clear.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   en       : advance by one (wraps at FRAME_BEATS-1)
//   clr      : load zero; takes priority over en
//   cnt      : current count
// ---------------------------------------------------------------------------
module frame_beat_cnt
  import fft_ctrl_pkg::*;
#(
  parameter int FRAME_BEATS = DEF_FRAME_BEATS,
  parameter int W           = $clog2(FRAME_BEATS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == W'(FRAME_BEATS - 1)) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/cu_mod1_1.sv
// ---------------------------------------------------------------------------
// cu_mod1_1
// Control unit for module-1 stage 1 (single-delay-feedback butterfly).
// Consumes the stage-0 beat handshake, tracks the frame position and the
// delay-line occupancy, and produces butterfly/rotation enables plus a
// re-timed valid/alert stream with its output-frame beat index.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   valid_in   : beat valid from stage 0
//   alert_in   : frame-start marker, only meaningful with valid_in
//   bf_en      : butterfly add/sub enable for the beat accepted last cycle
//   negj_en    : apply -j rotation to the butterfly output
//   tw_idx     : output-frame beat index, valid with valid_out
//   valid_out  : beat valid to the next module
//   alert_out  : pulse on the first output beat of each frame
//   sync_err   : sticky frame-misalignment flag
// All outputs are registered.
// ---------------------------------------------------------------------------
module cu_mod1_1
  import fft_ctrl_pkg::*;
#(
  parameter int HALF_DEPTH  = DEF_HALF_DEPTH,
  parameter int FRAME_BEATS = DEF_FRAME_BEATS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  input  logic                           alert_in,
  output logic                           bf_en,
  output logic                           negj_en,
  output logic [$clog2(FRAME_BEATS)-1:0] tw_idx,
  output logic                           valid_out,
  output logic                           alert_out,
  output logic                           sync_err
);

  localparam int CNT_W  = $clog2(FRAME_BEATS);
  localparam int DEP_W  = $clog2(HALF_DEPTH + 1);
  localparam int BF_BIT = $clog2(HALF_DEPTH);
  localparam int NJ_BIT = $clog2(2 * HALF_DEPTH);

  localparam logic [DEP_W-1:0] OCC_FULL  = DEP_W'(HALF_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_BEATS - 1);

  state_t           state_reg, state_next;
  logic [DEP_W-1:0] occ_reg, occ_next;
  logic [CNT_W-1:0] frm_cnt, out_cnt;
  logic [CNT_W-1:0] k_inc, k;
  logic             acc, restart, valid_next, sync_set, bf_next, negj_next;

  // frm_cnt holds the index of the most recently accepted beat.
  frame_beat_cnt #(.FRAME_BEATS(FRAME_BEATS)) u_frm_cnt (
    .clk (clk),
    .rst (rst),
    .en  (acc),
    .clr (restart),
    .cnt (frm_cnt)
  );

  // out_cnt numbers the outgoing beats; it only ever wraps, never restarts.
  frame_beat_cnt #(.FRAME_BEATS(FRAME_BEATS)) u_out_cnt (
    .clk (clk),
    .rst (rst),
    .en  (valid_next),
    .clr (1'b0),
    .cnt (out_cnt)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      occ_reg   <= '0;
    end else begin
      state_reg <= state_next;
      occ_reg   <= occ_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (acc) state_next = ACTIVE;
      ACTIVE:  if (acc && (k == LAST_BEAT)) state_next = FLUSH;
      FLUSH: begin
        // A new frame arriving during the drain keeps the pipe full.
        if (acc)                        state_next = ACTIVE;
        else if (occ_reg <= DEP_W'(1))  state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath-control logic (values registered below)
  always_comb begin
    acc        = 1'b0;
    occ_next   = occ_reg;
    valid_next = 1'b0;

    case (state_reg)
      ACTIVE:  acc = valid_in;
      IDLE:    acc = valid_in & alert_in;
      FLUSH:   acc = valid_in & alert_in & (occ_reg != '0);
      default: acc = 1'b0;
    endcase

    restart  = acc & alert_in;
    k_inc    = (frm_cnt == LAST_BEAT) ? '0 : frm_cnt + CNT_W'(1);
    k        = restart ? '0 : k_inc;
    // In ACTIVE the expected index is never 0, so any alert there is a slip.
    sync_set = restart & (state_reg == ACTIVE) & (k_inc != '0);

    bf_next   = acc & k[BF_BIT];
    negj_next = bf_next & k[NJ_BIT];

    if (state_reg == FLUSH) begin
      // Drain one stored beat per cycle; an accepted beat replaces the one
      // leaving, so occupancy holds.
      valid_next = (occ_reg != '0);
      if (!acc && (occ_reg != '0)) occ_next = occ_reg - DEP_W'(1);
    end else if (acc) begin
      if (occ_reg == OCC_FULL) valid_next = 1'b1;
      else                     occ_next   = occ_reg + DEP_W'(1);
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bf_en     <= 1'b0;
      negj_en   <= 1'b0;
      tw_idx    <= '0;
      valid_out <= 1'b0;
      alert_out <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      bf_en     <= bf_next;
      negj_en   <= negj_next;
      tw_idx    <= valid_next ? out_cnt : '0;
      valid_out <= valid_next;
      alert_out <= valid_next & (out_cnt == '0);
      sync_err  <= sync_err | sync_set;
    end
  end

endmodule
